// File: rtl/xnor_share_pkg.sv
// Shared types and helpers for the shared 6-bit XNOR sequencer.
// Holds the FSM encoding, datapath widths and the matching-bit popcount.
package xnor_share_pkg;

    localparam int DATA_W = 6;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_COUNT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum = sum + CNT_W'(v[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/b6xnor.sv
// Bitwise 6-bit XNOR unit, purely combinational (0 cycles).
// No flow control; the caller registers the output.
module b6xnor
    import xnor_share_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    assign y_o = ~(a_i ^ b_i);

endmodule

// File: rtl/xnor_share_ctrl.sv
// Round-robin shares one XNOR unit among N_REQ requesters; done 3 cycles after grant, 1 op / 4 cycles.
// Requests are only sampled in IDLE; a requester holds req and operands until it sees its grant.
module xnor_share_ctrl
    import xnor_share_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [DATA_W*N_REQ-1:0] a_in,
    input  logic [DATA_W*N_REQ-1:0] b_in,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       result,
    output logic [CNT_W-1:0]        match_cnt,
    output logic                    eq,
    output logic                    busy
);

    localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d;
    logic [DATA_W-1:0]  op_b_q, op_b_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]   match_q, match_d;
    logic               eq_q, eq_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   win;
    logic [DATA_W-1:0]  xnor_w;

    // Search starts just after the previous winner so every active requester is served in turn.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] w;
        logic             found;
        int               idx;
        w     = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && r[idx]) begin
                w     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win = rr_pick(req, last_q);

    b6xnor u_xnor (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .y_o (xnor_w)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        match_d  = match_q;
        eq_d     = eq_q;
        sel_d    = sel_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_EXEC;
                    sel_d   = win;
                    last_d  = win;
                    op_a_d  = a_in[DATA_W*win +: DATA_W];
                    op_b_d  = b_in[DATA_W*win +: DATA_W];
                    grant_d = N_REQ'(1) << win;
                end
            end
            ST_EXEC: begin
                x_d     = xnor_w;
                grant_d = '0;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                cnt_d   = popcount(x_q);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                result_d = x_q;
                match_d  = cnt_q;
                eq_d     = (cnt_q == CNT_W'(DATA_W));
                done_d   = N_REQ'(1) << sel_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            x_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            match_q  <= '0;
            eq_q     <= 1'b0;
            sel_q    <= '0;
            last_q   <= IDX_W'(N_REQ - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            match_q  <= match_d;
            eq_q     <= eq_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign result    = result_q;
    assign match_cnt = match_q;
    assign eq        = eq_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xnor_share_ctrl.sv
// Directed bench for xnor_share_ctrl with a scoreboard of expected responses.
module tb_xnor_share_ctrl;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [6*N-1:0] a_in;
    logic [6*N-1:0] b_in;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [5:0]    result;
    logic [2:0]    match_cnt;
    logic          eq;
    logic          busy;

    typedef struct {
        logic [N-1:0] done;
        logic [5:0]   res;
        logic [2:0]   cnt;
        logic         eq;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_gcyc = 0;

    xnor_share_ctrl #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .grant     (grant),
        .done      (done),
        .result    (result),
        .match_cnt (match_cnt),
        .eq        (eq),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] g, input logic [5:0] a, input logic [5:0] b);
        exp_t e;
        e.done = g;
        e.res  = ~(a ^ b);
        e.cnt  = 3'd0;
        for (int i = 0; i < 6; i++) if (e.res[i]) e.cnt = e.cnt + 3'd1;
        e.eq   = (e.cnt == 3'd6);
        return e;
    endfunction

    task automatic wait_grant(input logic [N-1:0] exp_g, input int exp_gap);
        int n;
        int w;
        n = 0;
        tick();
        n++;
        chk("done_clr", done, 0);
        while (grant === '0 && n < 16) begin
            tick();
            n++;
        end
        chk("grant", grant, exp_g);
        if (exp_gap > 0) chk("grant_gap", cyc - last_gcyc, exp_gap);
        last_gcyc = cyc;
        w = exp_g[1] ? 1 : 0;
        sb.push_back(model(exp_g, a_in[6*w +: 6], b_in[6*w +: 6]));
    endtask

    task automatic finish_op(input bit raise1);
        int   n;
        exp_t e;
        tick();
        n = 1;
        chk("grant_clr", grant, 0);
        chk("busy_exec", busy, 1);
        if (raise1) req = 2'b10;
        while (n < 8) begin
            tick();
            n++;
            if (done !== '0) break;
            chk("busy_wait", busy, 1);
        end
        chk("done_lat", n, 3);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("done", done, e.done);
            chk("result", result, e.res);
            chk("match_cnt", match_cnt, e.cnt);
            chk("eq", eq, e.eq);
            chk("busy_resp", busy, 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t drop;
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_eq", eq, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;

        // Full match on requester 0
        a_in[5:0] = 6'b101010; b_in[5:0] = 6'b101010; req = 2'b01;
        wait_grant(2'b01, 0); req = '0;
        finish_op(1'b0);

        // Total mismatch on requester 1
        a_in[11:6] = 6'b000000; b_in[11:6] = 6'b111111; req = 2'b10;
        wait_grant(2'b10, 0); req = '0;
        finish_op(1'b0);

        // Partial match on requester 0
        a_in[5:0] = 6'b110011; b_in[5:0] = 6'b100001; req = 2'b01;
        wait_grant(2'b01, 0); req = '0;
        finish_op(1'b0);

        // Fairness with both requests held from reset
        a_in[5:0] = 6'b111000; b_in[5:0] = 6'b000111;
        a_in[11:6] = 6'b011110; b_in[11:6] = 6'b011000;
        rst_n = 1'b0; req = 2'b11;
        tick();
        rst_n = 1'b1;
        wait_grant(2'b01, 0); finish_op(1'b0);
        wait_grant(2'b10, 4); finish_op(1'b0);
        wait_grant(2'b01, 4); finish_op(1'b0);
        wait_grant(2'b10, 4); finish_op(1'b0);
        req = '0;

        // Request raised while busy
        do_reset();
        a_in[5:0] = 6'b010101; b_in[5:0] = 6'b010111;
        a_in[11:6] = 6'b100100; b_in[11:6] = 6'b100100;
        req = 2'b01;
        wait_grant(2'b01, 0); req = '0;
        finish_op(1'b1);
        wait_grant(2'b10, 4); req = '0;
        finish_op(1'b0);

        // Reset while in EXEC
        a_in[5:0] = 6'b001100; b_in[5:0] = 6'b001100;
        req = 2'b01;
        wait_grant(2'b01, 0);
        drop = sb.pop_back();
        rst_n = 1'b0;
        req = 2'b11;
        #1;
        chk("mid_grant", grant, 0);
        chk("mid_done", done, 0);
        chk("mid_busy", busy, 0);
        chk("mid_result", result, 0);
        chk("mid_cnt", match_cnt, 0);
        chk("mid_eq", eq, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_done", done, 0);
        end
        rst_n = 1'b1;
        wait_grant(2'b01, 0);
        finish_op(1'b0);
        req = '0;
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
